// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Purpose  : Two-entry pipeline skid stage. The head payload sits in the main
//            register and a second payload can park in the skid register, so
//            in_ready comes from registered state only and never from
//            in_valid. An empty stage presents a NOP bubble on out_data. A
//            saturating counter records stalled cycles.
// Ports    : clk        - clock, all state on rising edge
//            rst        - asynchronous active-low reset
//            in_valid   - upstream payload valid
//            in_ready   - stage accepts a payload this cycle
//            in_data    - upstream payload
//            hold       - stall, freezes stage contents
//            flush      - discard all held payloads
//            out_valid  - downstream payload valid
//            out_ready  - downstream accepts payload
//            out_data   - head payload, or NOP_VAL when empty
//            occupancy  - entries held (0..2)
//            stall_cnt  - saturating count of stalled cycles
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
    parameter int          DATA_W  = 32,
    parameter logic [31:0] NOP_VAL = 32'h00000013,
    parameter int          CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              hold,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Bubble value, truncated or zero-extended to the payload width.
    localparam logic [DATA_W-1:0] c_nop     = DATA_W'(NOP_VAL);
    localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};

    // Encoding equals the number of entries held, so occupancy is the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_main;
    logic [DATA_W-1:0]  r_skid;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_accept;
    logic               w_emit;
    logic               w_stalled;

    // rst gates in_ready so nothing is offered as accepted while the stage
    // is being held in reset.
    assign in_ready  = rst && (r_state != ST_FULL) && !hold && !flush;
    assign out_valid = (r_state != ST_EMPTY) && !hold && !flush;
    assign out_data  = (r_state != ST_EMPTY) ? r_main : c_nop;
    assign occupancy = 2'(r_state);
    assign stall_cnt = r_stall_cnt;

    assign w_accept  = in_valid && in_ready;
    assign w_emit    = out_valid && out_ready;
    assign w_stalled = (hold && (r_state != ST_EMPTY)) || (out_valid && !out_ready);

    // Hold needs no explicit branch: it forces accept and emit low, so the
    // handshake-driven transitions below all fall through to "stay".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
            r_main  <= c_nop;
            r_skid  <= c_nop;
        end else if (flush) begin
            r_state <= ST_EMPTY;
            r_main  <= c_nop;
            r_skid  <= c_nop;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main  <= in_data;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_emit) begin
                        r_main <= in_data;
                    end else if (w_accept) begin
                        r_skid  <= in_data;
                        r_state <= ST_FULL;
                    end else if (w_emit) begin
                        r_main  <= c_nop;
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_emit) begin
                        r_main  <= r_skid;
                        r_skid  <= c_nop;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_main  <= c_nop;
                    r_skid  <= c_nop;
                end
            endcase
        end
    end

    // Stall counter survives flush; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_stalled && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_stage
// Purpose  : Directed self-checking bench for pipe_skid_stage. Two instances
//            share all inputs: the default one, and one with a 2-bit stall
//            counter used for the saturation case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

    localparam logic [31:0] c_a   = 32'h00108F93;
    localparam logic [31:0] c_b   = 32'hFE20D063;
    localparam logic [31:0] c_c   = 32'hDEADBEEF;
    localparam logic [31:0] c_nop = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        hold;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_data2;
    logic [1:0]  occupancy2;
    logic [1:0]  stall_cnt2;

    int n_vec = 0;
    int n_err = 0;

    pipe_skid_stage #(.DATA_W(32), .NOP_VAL(32'h00000013), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .hold(hold), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    pipe_skid_stage #(.DATA_W(32), .NOP_VAL(32'h00000013), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .hold(hold), .flush(flush), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .occupancy(occupancy2),
        .stall_cnt(stall_cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge; checks follow a 1-unit
    // settle, so every sample is well clear of the active edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        hold      = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        rst = 1'b0;
        settle();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'(c_nop));
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        rst = 1'b1;
        settle();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // ---------------- single payload, 1-cycle latency ----------------
        do_reset();
        in_valid  = 1'b1;
        in_data   = c_a;
        out_ready = 1'b1;
        settle();
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        settle();
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_data",  64'(out_data),  64'(c_a));
        chk("t1_occupancy", 64'(occupancy), 64'd1);
        cyc();
        settle();
        chk("t1_out_data_nop", 64'(out_data),  64'(c_nop));
        chk("t1_out_valid_0",  64'(out_valid), 64'd0);
        chk("t1_occupancy_0",  64'(occupancy), 64'd0);

        // ---------------- fill to two, drain in order ----------------
        do_reset();
        in_valid = 1'b1;
        in_data  = c_a;
        cyc();
        in_data = c_b;
        settle();
        chk("t2_in_ready_one", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        settle();
        chk("t2_occupancy_2", 64'(occupancy), 64'd2);
        chk("t2_in_ready_0",  64'(in_ready),  64'd0);
        chk("t2_head",        64'(out_data),  64'(c_a));
        out_ready = 1'b1;
        settle();
        chk("t2_out0_valid", 64'(out_valid), 64'd1);
        chk("t2_out0_data",  64'(out_data),  64'(c_a));
        cyc();
        settle();
        chk("t2_out1_valid", 64'(out_valid), 64'd1);
        chk("t2_out1_data",  64'(out_data),  64'(c_b));
        chk("t2_occupancy_1", 64'(occupancy), 64'd1);
        cyc();
        settle();
        chk("t2_drained_occ",   64'(occupancy), 64'd0);
        chk("t2_drained_valid", 64'(out_valid), 64'd0);
        // one stalled edge: state ONE with out_valid=1, out_ready=0
        chk("t2_stall_cnt", 64'(stall_cnt), 64'd1);

        // ---------------- hold freezes contents ----------------
        do_reset();
        in_valid = 1'b1;
        in_data  = c_a;
        cyc();
        in_data   = c_b;
        hold      = 1'b1;
        out_ready = 1'b1;
        settle();
        chk("t3_hold_out_valid", 64'(out_valid), 64'd0);
        chk("t3_hold_in_ready",  64'(in_ready),  64'd0);
        cyc();
        settle();
        chk("t3_hold_occ",  64'(occupancy), 64'd1);
        chk("t3_hold_data", 64'(out_data),  64'(c_a));
        cyc();
        hold     = 1'b0;
        in_valid = 1'b0;
        settle();
        chk("t3_stall_cnt",  64'(stall_cnt), 64'd2);
        chk("t3_occ",        64'(occupancy), 64'd1);
        chk("t3_emit_valid", 64'(out_valid), 64'd1);
        chk("t3_emit_data",  64'(out_data),  64'(c_a));
        cyc();
        settle();
        chk("t3_emitted_once", 64'(out_valid), 64'd0);
        chk("t3_occ_0",        64'(occupancy), 64'd0);

        // ---------------- flush beats hold and handshakes ----------------
        do_reset();
        in_valid = 1'b1;
        in_data  = c_a;
        cyc();
        in_data = c_b;
        cyc();
        settle();
        chk("t4_full", 64'(occupancy), 64'd2);
        flush     = 1'b1;
        hold      = 1'b1;
        in_data   = c_c;
        out_ready = 1'b1;
        settle();
        chk("t4_flush_out_valid", 64'(out_valid), 64'd0);
        chk("t4_flush_in_ready",  64'(in_ready),  64'd0);
        cyc();
        flush    = 1'b0;
        hold     = 1'b0;
        in_valid = 1'b0;
        settle();
        chk("t4_occ_0",      64'(occupancy), 64'd0);
        chk("t4_out_data",   64'(out_data),  64'(c_nop));
        chk("t4_out_valid",  64'(out_valid), 64'd0);
        cyc();
        settle();
        chk("t4_still_empty", 64'(occupancy), 64'd0);

        // ---------------- stall counter saturation (2-bit instance) ----------
        do_reset();
        in_valid = 1'b1;
        in_data  = c_a;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            settle();
            chk($sformatf("t5_sat_cnt_%0d", i), 64'(stall_cnt2), 64'((i < 3) ? i + 1 : 3));
        end
        chk("t5_wide_cnt", 64'(stall_cnt), 64'd6);
        chk("t5_occ",      64'(occupancy2), 64'd1);

        // ---------------- reset mid-transfer ----------------
        in_valid = 1'b1;
        in_data  = c_b;
        cyc();
        settle();
        chk("t6_full", 64'(occupancy), 64'd2);
        rst = 1'b0;
        settle();
        chk("t6_async_occ",      64'(occupancy), 64'd0);
        chk("t6_async_data",     64'(out_data),  64'(c_nop));
        chk("t6_async_in_ready", 64'(in_ready),  64'd0);
        chk("t6_async_cnt",      64'(stall_cnt), 64'd0);
        cyc();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = c_c;
        out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        settle();
        chk("t6_first_accept_occ",  64'(occupancy), 64'd1);
        chk("t6_first_accept_data", 64'(out_data),  64'(c_c));

        // ---------------- full throughput ----------------
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hA000_0000;
        cyc();
        for (int i = 1; i < 8; i++) begin
            in_data = 32'hA000_0000 + 32'(i);
            settle();
            chk($sformatf("t7_valid_%0d", i - 1), 64'(out_valid), 64'd1);
            chk($sformatf("t7_data_%0d", i - 1),  64'(out_data),  64'(32'hA000_0000 + 32'(i - 1)));
            chk($sformatf("t7_occ_%0d", i - 1),   64'(occupancy), 64'd1);
            chk($sformatf("t7_ready_%0d", i - 1), 64'(in_ready),  64'd1);
            cyc();
        end
        in_valid = 1'b0;
        settle();
        chk("t7_valid_7", 64'(out_valid), 64'd1);
        chk("t7_data_7",  64'(out_data),  64'(32'hA000_0007));
        cyc();
        settle();
        chk("t7_drained", 64'(occupancy), 64'd0);
        chk("t7_no_stall", 64'(stall_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits (min 1).
REQ-002 SHALL have parameter NOP_VAL, default 32'h00000013, bubble value on an empty stage (addi x0,x0,0), truncated/zero-extended to DATA_W.
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-004 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1: one clock; reset is asynchronous and active-low (0 = reset).
REQ-006 SHALL have port in_valid, input, 1, upstream payload valid.
REQ-007 SHALL have port in_ready, output, 1, stage accepts payload this cycle.
REQ-008 SHALL have port in_data, input, DATA_W, upstream payload (e.g. packed decode bundle).
REQ-009 SHALL have port hold, input, 1, pipeline stall, freezes stage contents.
REQ-010 SHALL have port flush, input, 1, discard all held payloads.
REQ-011 SHALL have port out_valid, output, 1, downstream payload valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts payload.
REQ-013 SHALL have port out_data, output, DATA_W, head payload, or NOP_VAL when empty.
REQ-014 SHALL have port occupancy, output, 2, entries held (0, 1 or 2).
REQ-015 SHALL have port stall_cnt, output, CNT_W, saturating count of stalled cycles.

Function
REQ-016 SHALL hold two registers: main (head) and skid, plus state EMPTY/ONE/FULL; occupancy SHALL be 0/1/2 respectively, driven from registers.
REQ-017 SHALL drive in_ready = (state != FULL) && !hold && !flush, combinational from state and controls only; no in_valid -> in_ready path.
REQ-018 SHALL drive out_valid = (state != EMPTY) && !hold && !flush; out_data SHALL equal main when state != EMPTY, else NOP_VAL.
REQ-019 SHALL define accept = in_valid && in_ready and emit = out_valid && out_ready, both evaluated in the same cycle.
REQ-020 SHALL transition EMPTY: accept -> ONE, main <= in_data; else stay.
REQ-021 SHALL transition ONE: accept&&emit -> ONE, main <= in_data; accept only -> FULL, skid <= in_data; emit only -> EMPTY, main <= NOP_VAL; neither -> stay.
REQ-022 SHALL transition FULL: emit -> ONE, main <= skid, skid <= NOP_VAL; else stay; no accept possible in FULL.
REQ-023 SHALL, with hold=1 and flush=0, keep state, main and skid unchanged; no payload enters or leaves.
REQ-024 SHALL, with flush=1 (priority over hold and all handshakes), go to EMPTY next edge with main and skid <= NOP_VAL; in_data that cycle is discarded.
REQ-025 SHALL increment stall_cnt by 1 per cycle when (hold && state != EMPTY) or (out_valid && !out_ready), saturating at all-ones, never wrapping.
REQ-026 SHALL clear stall_cnt only on reset; flush does not clear it.
REQ-027 SHALL deliver payloads in accept order with zero loss and zero duplication; latency accept-to-out_valid is exactly 1 cycle when EMPTY.
REQ-028 SHALL sustain one transfer per cycle when out_ready is held high and hold/flush low.

Reset
REQ-029 SHALL, on rst=0, asynchronously force state EMPTY, main and skid = NOP_VAL, stall_cnt = 0, hence out_valid=0, out_data=NOP_VAL, occupancy=0, in_ready=0 while reset asserted.
REQ-030 SHALL, on reset assertion mid-transfer, drop all held payloads; first accept is possible on the first rising edge after rst returns to 1.

Verification
REQ-031 SHALL test: reset, then in_data=32'h00108F93 valid 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=32'h00108F93, occupancy=1; following cycle out_data=32'h00000013.
REQ-032 SHALL test: out_ready=0, push 32'h00108F93 then 32'hFE20D063 -> occupancy=2, in_ready=0; raise out_ready -> outputs 32'h00108F93 then 32'hFE20D063 in order.
REQ-033 SHALL test: occupancy=1 holding 32'h00108F93, hold=1 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=0, contents unchanged, stall_cnt=2; hold=0 -> payload emitted once.
REQ-034 SHALL test: occupancy=2, flush=1 together with hold=1 and in_valid=1 -> next cycle occupancy=0, out_data=32'h00000013, no payload emitted.
REQ-035 SHALL test: CNT_W=2, out_ready=0 with occupancy=1 for 6 cycles -> stall_cnt 1,2,3,3,3,3.
REQ-036 SHALL test: continuous in_valid=1, out_ready=1, 8 sequential values -> 8 outputs in order, one per cycle, occupancy stays 1.
